dmem_result_streamer: RTL and testbench
=======================================

// Module: dmem_result_streamer
// PURPOSE
//  Drains the downsampled image from data memory once the processor raises finish_signal.
//  Reads LENGTH bytes starting at BASE_ADDR through the DMem read port.
//  Presents them in address order as a valid/ready byte stream to the UART transmitter.
//  Sits directly downstream of the CPU/DMem complex; it only reads DMem and never writes it.
// PARAMETERS
//  ADDR_W     16       DMem address width
//  DATA_W     8        DMem word / stream byte width
//  BASE_ADDR  16'd0    first DMem address of the result image
//  LENGTH     16'd16384  number of bytes to stream; 0 is legal
// PORTS
//  clk            in   1       system clock; all logic on rising edge
//  reset          in   1       synchronous, active-high reset
//  finish_signal  in   1       processor-done level from DMem/CPU; rising edge starts a dump
//  mem_rd_en      out  1       DMem read strobe, one cycle per address
//  mem_addr       out  ADDR_W  DMem read address (registered)
//  mem_rd_data    in   DATA_W  DMem read data, valid exactly 1 cycle after mem_rd_en
//  tx_data        out  DATA_W  stream byte
//  tx_valid       out  1       tx_data valid; held until accepted
//  tx_ready       in   1       sink accepts when tx_valid && tx_ready on a rising edge
//  busy           out  1       high from start until the last byte is accepted
//  done           out  1       single-cycle pulse after the last byte is accepted
//  byte_count     out  ADDR_W  bytes accepted so far in the current or last dump
// BEHAVIOUR
//  Reset values: mem_rd_en=0, mem_addr=BASE_ADDR, tx_valid=0, tx_data=0, busy=0, done=0, byte_count=0, state=IDLE.
//  finish_d register samples finish_signal each cycle; start = finish_signal & ~finish_d.
//  States: IDLE -> REQ -> WAIT -> SEND -> (REQ | DONE) -> IDLE.
//   IDLE: on start with LENGTH!=0: busy=1, byte_count=0, mem_addr=BASE_ADDR -> REQ.
//     On start with LENGTH==0: -> DONE, no reads.
//   REQ : mem_rd_en=1 for exactly one cycle at mem_addr -> WAIT.
//   WAIT: capture mem_rd_data into tx_data, tx_valid=1 -> SEND.
//   SEND: hold tx_data/tx_valid stable until tx_ready.
//     On accept: tx_valid=0, byte_count+1, mem_addr+1.
//     Then -> DONE if byte_count+1==LENGTH, else -> REQ.
//   DONE: done=1 for one cycle, busy=0 -> IDLE.
//  Throughput: with tx_ready tied high, one byte per 3 cycles.
//  First tx_valid is asserted 3 cycles after the start edge.
//  tx_data must not change while tx_valid=1 and tx_ready=0.
//  mem_addr wraps modulo 2^ADDR_W; BASE_ADDR+LENGTH may cross the top of memory.
//  byte_count holds its final value after DONE until the next start.
//  A finish_signal edge while busy is ignored; finish_signal held high does not restart a dump.
//  A new dump needs finish_signal to fall and rise again.
//  Reset asserted mid-dump: next cycle all outputs are at reset values and any pending byte is dropped.
//  Reset does not clear DMem.
//  mem_rd_en is never asserted outside REQ; no DMem write path exists in this block.
// STRUCTURE
//  Shared package streamer_pkg holds:
//   - state enum (IDLE, REQ, WAIT, SEND, DONE) as 3-bit localparams;
//   - default BASE_ADDR and LENGTH constants, shared with the DMem image-layout constants.
//  No sub-module.
//  Edge detect, address counter and byte counter are inline regs in this module.
//  The FSM is a single registered next-state block.
// TESTING
//  1 Dump with sink always ready.
//    Stimulus: DMem[0..3]=8'h11,22,33,44; LENGTH=4; finish_signal 0->1; tx_ready=1.
//    Response: bytes 11,22,33,44 in order, 3 cycles apart.
//    Response: done pulses once; byte_count=4; busy low afterwards.
//  2 Backpressure.
//    Stimulus: tx_ready low for 5 cycles while byte 2 is valid.
//    Response: tx_data stays 8'h22 and tx_valid stays 1 throughout; no extra mem_rd_en; byte_count stalls at 1.
//  3 Start edge handling.
//    Stimulus: finish_signal held high for 100 cycles after the dump completes.
//    Response: no second dump.
//    Stimulus: finish_signal toggles 0->1 mid-dump.
//    Response: ignored; exactly LENGTH bytes are sent.
//  4 Reset mid-operation.
//    Stimulus: assert reset in SEND after 2 bytes.
//    Response: next cycle tx_valid=0, busy=0, byte_count=0, mem_addr=BASE_ADDR.
//    Stimulus: a new finish_signal edge.
//    Response: restarts from BASE_ADDR.
//  5 Boundaries.
//    Stimulus: LENGTH=0.
//    Response: done 2 cycles after the edge, no mem_rd_en.
//    Stimulus: BASE_ADDR=16'hFFFE, LENGTH=3.
//    Response: reads FFFE, FFFF, 0000.
//  6 Random sink.
//    Stimulus: random tx_ready, LENGTH=256.
//    Response: scoreboard matches DMem contents byte-for-byte; each byte accepted exactly once.

Source files
------------

// File: rtl/streamer_pkg.sv
// Shared definitions for the result streamer: FSM state encoding and the
// default placement of the downsampled image inside DMem.
package streamer_pkg;

    // Streamer FSM states, fixed 3-bit encoding
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    // DMem image layout: the processor leaves its result image here
    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'd0;
    localparam logic [15:0] DEFAULT_LENGTH    = 16'd16384;

endpackage

// File: rtl/dmem_result_streamer.sv
// Reads the result image out of DMem after the processor signals completion
// and hands it, one byte at a time in address order, to a valid/ready sink.
module dmem_result_streamer
    import streamer_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter logic [ADDR_W-1:0] LENGTH    = ADDR_W'(DEFAULT_LENGTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              finish_signal,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] byte_count
);

    state_t            state;
    state_t            state_next;
    logic              finish_d;
    logic              start;
    logic              accept;
    logic              last_byte;
    logic [ADDR_W-1:0] count_inc;

    assign start     = finish_signal & ~finish_d;
    assign accept    = tx_valid & tx_ready;
    assign count_inc = byte_count + 1'b1;
    assign last_byte = (count_inc == LENGTH);
    assign mem_rd_en = (state == REQ);

    // Delayed copy of finish_signal for rising-edge detection; it tracks the
    // input during reset too so a level held high across reset cannot start a dump
    always_ff @(posedge clk) begin
        finish_d <= finish_signal;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start edges are only honoured in IDLE, so edges while busy are ignored
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (LENGTH == '0) ? DONE : REQ;
                end
            end
            REQ:  state_next = WAIT;
            WAIT: state_next = SEND;
            SEND: begin
                if (accept) begin
                    state_next = last_byte ? DONE : REQ;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: address/byte counters, stream register, status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr   <= BASE_ADDR;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            byte_count <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        byte_count <= '0;
                        mem_addr   <= BASE_ADDR;
                        busy       <= (LENGTH != '0);
                    end
                end
                WAIT: begin
                    tx_data  <= mem_rd_data;
                    tx_valid <= 1'b1;
                end
                SEND: begin
                    if (accept) begin
                        tx_valid   <= 1'b0;
                        byte_count <= count_inc;
                        mem_addr   <= mem_addr + 1'b1;
                        if (last_byte) begin
                            busy <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_result_streamer.sv
// Directed bench for dmem_result_streamer. Four instances with different
// image layouts share one DMem model and one clock/reset.
module tb_dmem_result_streamer;

    logic       clk;
    logic       reset;
    logic [7:0] dmem [0:65535];

    int checks = 0;
    int errors = 0;

    // Instance A: BASE 0, LENGTH 4
    logic        fin_a, rd_en_a, tx_valid_a, ready_a, busy_a, done_a;
    logic [15:0] addr_a, count_a;
    logic [7:0]  rd_data_a, tx_data_a;
    // Instance B: LENGTH 0
    logic        fin_b, rd_en_b, tx_valid_b, ready_b, busy_b, done_b;
    logic [15:0] addr_b, count_b;
    logic [7:0]  rd_data_b, tx_data_b;
    // Instance C: BASE FFFE, LENGTH 3 (wraps)
    logic        fin_c, rd_en_c, tx_valid_c, ready_c, busy_c, done_c;
    logic [15:0] addr_c, count_c;
    logic [7:0]  rd_data_c, tx_data_c;
    // Instance D: BASE 0100, LENGTH 256 (random sink)
    logic        fin_d, rd_en_d, tx_valid_d, ready_d, busy_d, done_d;
    logic [15:0] addr_d, count_d;
    logic [7:0]  rd_data_d, tx_data_d;

    logic [15:0] rdq_a [$];
    logic [15:0] rdq_b [$];
    logic [15:0] rdq_c [$];
    logic [15:0] rdq_d [$];
    logic [7:0]  acc_a [$];
    logic [7:0]  acc_c [$];
    logic [7:0]  acc_d [$];
    int          done_cnt_a = 0;
    int          stab_err_a = 0;
    int          stab_err_d = 0;
    logic        hold_a = 1'b0, hold_d = 1'b0;
    logic [7:0]  prev_a = 8'h00, prev_d = 8'h00;

    dmem_result_streamer #(.BASE_ADDR(16'h0000), .LENGTH(16'd4)) dut_a (
        .clk(clk), .reset(reset), .finish_signal(fin_a), .mem_rd_en(rd_en_a),
        .mem_addr(addr_a), .mem_rd_data(rd_data_a), .tx_data(tx_data_a),
        .tx_valid(tx_valid_a), .tx_ready(ready_a), .busy(busy_a), .done(done_a),
        .byte_count(count_a));

    dmem_result_streamer #(.BASE_ADDR(16'h0000), .LENGTH(16'd0)) dut_b (
        .clk(clk), .reset(reset), .finish_signal(fin_b), .mem_rd_en(rd_en_b),
        .mem_addr(addr_b), .mem_rd_data(rd_data_b), .tx_data(tx_data_b),
        .tx_valid(tx_valid_b), .tx_ready(ready_b), .busy(busy_b), .done(done_b),
        .byte_count(count_b));

    dmem_result_streamer #(.BASE_ADDR(16'hFFFE), .LENGTH(16'd3)) dut_c (
        .clk(clk), .reset(reset), .finish_signal(fin_c), .mem_rd_en(rd_en_c),
        .mem_addr(addr_c), .mem_rd_data(rd_data_c), .tx_data(tx_data_c),
        .tx_valid(tx_valid_c), .tx_ready(ready_c), .busy(busy_c), .done(done_c),
        .byte_count(count_c));

    dmem_result_streamer #(.BASE_ADDR(16'h0100), .LENGTH(16'd256)) dut_d (
        .clk(clk), .reset(reset), .finish_signal(fin_d), .mem_rd_en(rd_en_d),
        .mem_addr(addr_d), .mem_rd_data(rd_data_d), .tx_data(tx_data_d),
        .tx_valid(tx_valid_d), .tx_ready(ready_d), .busy(busy_d), .done(done_d),
        .byte_count(count_d));

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DMem model: read data one cycle after the strobe, plus logging of
    // read addresses, accepted bytes, done pulses and hold-stability violations
    always @(posedge clk) begin
        if (rd_en_a) begin rd_data_a <= dmem[addr_a]; rdq_a.push_back(addr_a); end
        if (rd_en_b) begin rd_data_b <= dmem[addr_b]; rdq_b.push_back(addr_b); end
        if (rd_en_c) begin rd_data_c <= dmem[addr_c]; rdq_c.push_back(addr_c); end
        if (rd_en_d) begin rd_data_d <= dmem[addr_d]; rdq_d.push_back(addr_d); end
        if (tx_valid_a && ready_a) acc_a.push_back(tx_data_a);
        if (tx_valid_c && ready_c) acc_c.push_back(tx_data_c);
        if (tx_valid_d && ready_d) acc_d.push_back(tx_data_d);
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (!reset && hold_a && (!tx_valid_a || tx_data_a != prev_a)) stab_err_a <= stab_err_a + 1;
        if (!reset && hold_d && (!tx_valid_d || tx_data_d != prev_d)) stab_err_d <= stab_err_d + 1;
        hold_a <= tx_valid_a && !ready_a && !reset;
        hold_d <= tx_valid_d && !ready_d && !reset;
        prev_a <= tx_data_a;
        prev_d <= tx_data_d;
    end

    // Advance the clock n cycles; inputs driven before the call take effect
    // at the next edge, and outputs are sampled 1 time unit after each edge
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [7:0] exp_a [4];
        logic [7:0] r;
        exp_a[0] = 8'h11; exp_a[1] = 8'h22; exp_a[2] = 8'h33; exp_a[3] = 8'h44;

        for (int a = 0; a < 65536; a++) dmem[a] = 8'(a) ^ 8'h3C;
        dmem[0] = 8'h11; dmem[1] = 8'h22; dmem[2] = 8'h33; dmem[3] = 8'h44;
        dmem[16'hFFFE] = 8'hA5;
        dmem[16'hFFFF] = 8'h5A;
        for (int i = 0; i < 256; i++) begin
            r = 8'($urandom);
            dmem[16'h0100 + i] = r;
        end

        reset = 1'b1;
        fin_a = 0; fin_b = 0; fin_c = 0; fin_d = 0;
        ready_a = 0; ready_b = 1; ready_c = 0; ready_d = 0;
        rd_data_a = 0; rd_data_b = 0; rd_data_c = 0; rd_data_d = 0;
        applyStimulus(3);

        $display("[TB] reset values");
        checkOutput("rst_rd_en", rd_en_a, 1'b0);
        checkOutput("rst_addr", addr_a, 16'h0000);
        checkOutput("rst_addr_c", addr_c, 16'hFFFE);
        checkOutput("rst_valid", tx_valid_a, 1'b0);
        checkOutput("rst_data", tx_data_a, 8'h00);
        checkOutput("rst_busy", busy_a, 1'b0);
        checkOutput("rst_done", done_a, 1'b0);
        checkOutput("rst_count", count_a, 16'd0);
        reset = 1'b0;
        applyStimulus(2);

        $display("[TB] dump with sink always ready");
        ready_a = 1'b1;
        fin_a = 1'b1;
        applyStimulus(1);
        checkOutput("t1_rd_en_c1", rd_en_a, 1'b1);
        checkOutput("t1_addr_c1", addr_a, 16'h0000);
        checkOutput("t1_busy_c1", busy_a, 1'b1);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1);
            checkOutput($sformatf("t1_novalid_wait%0d", b), tx_valid_a, 1'b0);
            applyStimulus(1);
            checkOutput($sformatf("t1_valid%0d", b), tx_valid_a, 1'b1);
            checkOutput($sformatf("t1_data%0d", b), tx_data_a, exp_a[b]);
            applyStimulus(1);
            checkOutput($sformatf("t1_count%0d", b), count_a, 16'(b + 1));
            checkOutput($sformatf("t1_dropvalid%0d", b), tx_valid_a, 1'b0);
        end
        checkOutput("t1_busy_end", busy_a, 1'b0);
        checkOutput("t1_done_early", done_a, 1'b0);
        applyStimulus(1);
        checkOutput("t1_done_pulse", done_a, 1'b1);
        applyStimulus(1);
        checkOutput("t1_done_clear", done_a, 1'b0);
        checkOutput("t1_reads", rdq_a.size(), 4);

        $display("[TB] finish held high");
        applyStimulus(100);
        checkOutput("t3_no_restart_reads", rdq_a.size(), 4);
        checkOutput("t3_done_count", done_cnt_a, 1);
        checkOutput("t3_count_held", count_a, 16'd4);
        checkOutput("t3_busy", busy_a, 1'b0);

        $display("[TB] backpressure and mid-dump edge");
        fin_a = 1'b0;
        applyStimulus(1);
        rdq_a.delete();
        acc_a.delete();
        fin_a = 1'b1;
        applyStimulus(5);
        ready_a = 1'b0;
        applyStimulus(1);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("t2_data_k%0d", k), tx_data_a, 8'h22);
            checkOutput($sformatf("t2_valid_k%0d", k), tx_valid_a, 1'b1);
            checkOutput($sformatf("t2_count_k%0d", k), count_a, 16'd1);
            checkOutput($sformatf("t2_rd_en_k%0d", k), rd_en_a, 1'b0);
            if (k == 1) fin_a = 1'b0;
            if (k == 2) fin_a = 1'b1;
            applyStimulus(1);
        end
        checkOutput("t2_reads_stalled", rdq_a.size(), 2);
        ready_a = 1'b1;
        for (int i = 0; i < 100 && done_a !== 1'b1; i++) applyStimulus(1);
        checkOutput("t2_done_seen", done_a, 1'b1);
        checkOutput("t2_count_final", count_a, 16'd4);
        checkOutput("t2_bytes", acc_a.size(), 4);
        for (int b = 0; b < 4 && b < acc_a.size(); b++)
            checkOutput($sformatf("t2_byte%0d", b), acc_a[b], exp_a[b]);
        applyStimulus(20);
        checkOutput("t3_edge_ignored_reads", rdq_a.size(), 4);
        checkOutput("t2_hold_stable", stab_err_a, 0);

        $display("[TB] reset mid-dump");
        fin_a = 1'b0;
        applyStimulus(1);
        fin_a = 1'b1;
        applyStimulus(7);
        ready_a = 1'b0;
        for (int i = 0; i < 10 && tx_valid_a !== 1'b1; i++) applyStimulus(1);
        checkOutput("t4_in_send", tx_valid_a, 1'b1);
        checkOutput("t4_two_sent", count_a, 16'd2);
        reset = 1'b1;
        applyStimulus(1);
        checkOutput("t4_valid", tx_valid_a, 1'b0);
        checkOutput("t4_busy", busy_a, 1'b0);
        checkOutput("t4_count", count_a, 16'd0);
        checkOutput("t4_addr", addr_a, 16'h0000);
        checkOutput("t4_rd_en", rd_en_a, 1'b0);
        reset = 1'b0;
        ready_a = 1'b1;
        fin_a = 1'b0;
        applyStimulus(1);
        rdq_a.delete();
        acc_a.delete();
        fin_a = 1'b1;
        applyStimulus(1);
        checkOutput("t4_restart_rd_en", rd_en_a, 1'b1);
        checkOutput("t4_restart_addr", addr_a, 16'h0000);
        applyStimulus(2);
        checkOutput("t4_restart_data", tx_data_a, 8'h11);
        for (int i = 0; i < 100 && done_a !== 1'b1; i++) applyStimulus(1);
        checkOutput("t4_done_seen", done_a, 1'b1);
        checkOutput("t4_bytes", acc_a.size(), 4);
        checkOutput("t4_reads", rdq_a.size(), 4);

        $display("[TB] zero length");
        fin_b = 1'b1;
        applyStimulus(1);
        checkOutput("t5_len0_done_c1", done_b, 1'b0);
        checkOutput("t5_len0_busy", busy_b, 1'b0);
        applyStimulus(1);
        checkOutput("t5_len0_done_c2", done_b, 1'b1);
        checkOutput("t5_len0_count", count_b, 16'd0);
        applyStimulus(1);
        checkOutput("t5_len0_done_c3", done_b, 1'b0);
        checkOutput("t5_len0_reads", rdq_b.size(), 0);

        $display("[TB] address wrap");
        ready_c = 1'b1;
        fin_c = 1'b1;
        for (int i = 0; i < 50 && done_c !== 1'b1; i++) applyStimulus(1);
        checkOutput("t5_wrap_done", done_c, 1'b1);
        checkOutput("t5_wrap_reads", rdq_c.size(), 3);
        checkOutput("t5_wrap_bytes", acc_c.size(), 3);
        if (rdq_c.size() == 3 && acc_c.size() == 3) begin
            checkOutput("t5_wrap_addr0", rdq_c[0], 16'hFFFE);
            checkOutput("t5_wrap_addr1", rdq_c[1], 16'hFFFF);
            checkOutput("t5_wrap_addr2", rdq_c[2], 16'h0000);
            checkOutput("t5_wrap_byte0", acc_c[0], 8'hA5);
            checkOutput("t5_wrap_byte1", acc_c[1], 8'h5A);
            checkOutput("t5_wrap_byte2", acc_c[2], 8'h11);
        end
        checkOutput("t5_wrap_count", count_c, 16'd3);
        checkOutput("t5_wrap_addr_end", addr_c, 16'h0001);

        $display("[TB] random sink");
        fin_d = 1'b1;
        for (int i = 0; i < 4000 && done_d !== 1'b1; i++) begin
            ready_d = 1'($urandom_range(0, 1));
            applyStimulus(1);
        end
        checkOutput("t6_done", done_d, 1'b1);
        checkOutput("t6_bytes", acc_d.size(), 256);
        checkOutput("t6_reads", rdq_d.size(), 256);
        checkOutput("t6_count", count_d, 16'd256);
        checkOutput("t6_hold_stable", stab_err_d, 0);
        for (int i = 0; i < 256 && i < acc_d.size(); i++)
            checkOutput($sformatf("t6_byte%0d", i), acc_d[i], dmem[16'h0100 + i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
